// File: rtl/sclk_rate_ctrl.sv
// sclk_rate_ctrl: debounced switch-driven SCLK divider with boundary-only rate changes and a TICK on each rising edge.
module sclk_rate_ctrl #(
    parameter int BASE_DIV   = 2,
    parameter int STABLE_CYC = 4,
    parameter int CNT_W      = 32
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] SW,
    input  logic       EN,
    output logic       SCLK,
    output logic       TICK,
    output logic [7:0] ACT_SEL,
    output logic       RUNNING
);
    localparam int STAB_W = $clog2(STABLE_CYC + 1);
    typedef enum logic [1:0] {HALT, LOW, HIGH} state_t;
    state_t r_state;
    logic [7:0] r_s1, r_s2, r_cand, r_filt;
    logic [STAB_W-1:0] r_stab;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_reload;
    assign w_reload = CNT_W'(BASE_DIV) * (CNT_W'(r_filt) + CNT_W'(1)) - CNT_W'(1);
    assign RUNNING  = r_state != HALT;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_cand <= '0;
            r_filt <= '0;
            r_stab <= '0;
        end else begin
            r_s1 <= SW;
            r_s2 <= r_s1;
            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_stab <= '0;
            end else if (r_stab == STAB_W'(STABLE_CYC - 1)) begin
                r_filt <= r_cand;
            end else begin
                r_stab <= r_stab + STAB_W'(1);
            end
        end
    end
    // rate is sampled from r_filt only at phase boundaries, so a running phase is never cut short
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= HALT;
            r_cnt   <= '0;
            SCLK    <= 1'b0;
            TICK    <= 1'b0;
            ACT_SEL <= '0;
        end else begin
            TICK <= 1'b0;
            case (r_state)
                HALT: begin
                    SCLK    <= 1'b0;
                    ACT_SEL <= r_filt;
                    if (EN && r_filt != 8'd0) begin
                        r_state <= LOW;
                        r_cnt   <= w_reload;
                    end
                end
                LOW: begin
                    if (!EN) begin
                        r_state <= HALT;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        ACT_SEL <= r_filt;
                        if (r_filt == 8'd0) begin
                            r_state <= HALT;
                        end else begin
                            r_state <= HIGH;
                            SCLK    <= 1'b1;
                            TICK    <= 1'b1;
                            r_cnt   <= w_reload;
                        end
                    end
                end
                HIGH: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        ACT_SEL <= r_filt;
                        SCLK    <= 1'b0;
                        if (!EN || r_filt == 8'd0) begin
                            r_state <= HALT;
                        end else begin
                            r_state <= LOW;
                            r_cnt   <= w_reload;
                        end
                    end
                end
                default: r_state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_sclk_rate_ctrl.sv
// tb_sclk_rate_ctrl: directed and randomized checks of sclk_rate_ctrl against a phase-level reference model.
module tb_sclk_rate_ctrl;
    localparam int BD = 2;
    localparam int SC = 4;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] SW = 8'd0;
    logic       EN = 1'b0;
    logic       SCLK, TICK, RUNNING;
    logic [7:0] ACT_SEL;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_tick = -1;
    int exp_period = 0;
    sclk_rate_ctrl #(.BASE_DIV(BD), .STABLE_CYC(SC), .CNT_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .SW(SW), .EN(EN),
        .SCLK(SCLK), .TICK(TICK), .ACT_SEL(ACT_SEL), .RUNNING(RUNNING)
    );
    always #5 CLK = ~CLK;
    // model: synchronizer images, recent synchronized samples, and phase length/age
    logic [7:0] m_sw1, m_sw2, m_filt, m_act;
    logic       m_sclk, m_tick;
    logic [7:0] hist[$];
    int m_state, m_len, m_age;
    function automatic int plen(input logic [7:0] s);
        return BD * (int'(s) + 1);
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask
    task automatic model_reset();
        m_sw1 = 0; m_sw2 = 0; m_filt = 0; m_act = 0; m_sclk = 0; m_tick = 0;
        m_state = 0; m_len = 0; m_age = 0;
        hist = {};
        for (int i = 0; i <= SC; i++) hist.push_back(8'd0);
    endtask
    task automatic start_phase(input int st);
        m_state = st;
        m_len = plen(m_filt);
        m_age = 0;
    endtask
    task automatic model_edge();
        bit same;
        m_tick = 0;
        if (m_state == 0) begin
            m_act = m_filt;
            if (EN && m_filt != 0) start_phase(1);
        end else if (m_state == 1 && !EN) begin
            m_state = 0;
        end else if (m_age < m_len - 1) begin
            m_age++;
        end else begin
            m_act = m_filt;
            if (m_state == 1) begin
                if (m_filt == 0) m_state = 0;
                else begin start_phase(2); m_sclk = 1; m_tick = 1; end
            end else begin
                m_sclk = 0;
                if (!EN || m_filt == 0) m_state = 0;
                else start_phase(1);
            end
        end
        // a code is accepted once SC+1 consecutive synchronized samples agree
        hist.push_back(m_sw2);
        if (hist.size() > SC + 1) void'(hist.pop_front());
        same = 1;
        foreach (hist[i]) if (hist[i] != m_sw2) same = 0;
        if (same) m_filt = m_sw2;
        m_sw2 = m_sw1;
        m_sw1 = SW;
    endtask
    task automatic step();
        @(posedge CLK);
        model_edge();
        cyc++;
        #1;
        check("sclk", 32'(SCLK), 32'(m_sclk));
        check("tick", 32'(TICK), 32'(m_tick));
        check("act_sel", 32'(ACT_SEL), 32'(m_act));
        check("running", 32'(RUNNING), 32'(m_state != 0));
        if (TICK && exp_period != 0) begin
            if (last_tick >= 0) check("period", 32'(cyc - last_tick), 32'(exp_period));
            last_tick = cyc;
        end
    endtask
    task automatic do_reset();
        #2 RST_N = 1'b0;
        model_reset();
        #1;
        check("rst_sclk", 32'(SCLK), 0);
        check("rst_tick", 32'(TICK), 0);
        check("rst_act", 32'(ACT_SEL), 0);
        check("rst_running", 32'(RUNNING), 0);
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
    endtask
    task automatic wait_tick();
        for (int i = 0; i < 1200 && !TICK; i++) step();
        check("wait_tick", 32'(TICK), 1);
    endtask
    initial begin
        int n;
        model_reset();
        SW = 8'd0; EN = 1'b1;
        do_reset();
        repeat (50) step();
        SW = 8'd1; exp_period = 2 * BD * 2; last_tick = -1;
        repeat (60) step();
        wait_tick();
        step();
        SW = 8'd3; exp_period = 0;
        repeat (80) step();
        SW = 8'd1;
        repeat (40) step();
        exp_period = 2 * BD * 2; last_tick = -1;
        for (int i = 0; i < 40; i++) begin
            SW = (i % 6 < 3) ? 8'd1 : 8'd2;
            step();
        end
        exp_period = 0;
        wait_tick();
        step();
        EN = 1'b0;
        repeat (10) step();
        EN = 1'b1;
        repeat (12) step();
        wait_tick();
        for (int i = 0; i < 40 && SCLK; i++) step();
        check("low_seen", 32'(SCLK), 0);
        step();
        EN = 1'b0;
        repeat (6) step();
        EN = 1'b1;
        repeat (20) step();
        SW = 8'd0;
        repeat (30) step();
        SW = 8'd1;
        repeat (20) step();
        wait_tick();
        step();
        do_reset();
        n = 0;
        for (int i = 0; i < 20 && !RUNNING; i++) begin step(); n++; end
        check("restart_edges", 32'(n), 32'(SC + 4));
        for (int seg = 0; seg < 300; seg++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) SW = 8'd0;
            else if (r < 13) SW = 8'($urandom_range(1, 4));
            else if (r < 17) SW = 8'($urandom_range(5, 20));
            else if (r == 17) SW = 8'd255;
            EN = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 79) == 0) do_reset();
            repeat ($urandom_range(1, 16)) step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
